// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer, plus forwarding tap and stall counter.
// Latency: 1 cycle from accept to out_valid when empty (or when draining); sustains one transfer per cycle.
// Backpressure: in_ready is a flop equal to "skid empty"; it never depends combinationally on out_ready.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   flush                     synchronous clear of both entries, highest priority
//   in_valid/in_ready         upstream handshake; in_ctrl/in_rd/in_data carry the entry
//   out_valid/out_ready       downstream handshake; out_ctrl/out_rd/out_data present the main entry
//   fwd_valid/fwd_rd/fwd_data forwarding tap decoded from the main entry (valid only for register writes)
//   stall_cnt                 saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid #(
    parameter int                DATA_W   = 16,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = 8'h01,
    parameter int                RD_W     = 4,
    parameter int                WE_BIT   = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [RD_W-1:0]    skid_rd;
    logic [DATA_W-1:0]  skid_data;

    // Main entry lives directly in the out_* flops; skid holds the entry that
    // arrived while main was stalled. Empty entries hold the reset pattern so
    // the forwarding tap can never see a stale register-write bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RST;
            out_rd    <= '0;
            out_data  <= '0;
            skid_ctrl <= CTRL_RST;
            skid_rd   <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Any drain this cycle still completes downstream; offered input is dropped.
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_RST;
            out_rd    <= '0;
            out_data  <= '0;
            skid_ctrl <= CTRL_RST;
            skid_rd   <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_valid) begin
                        state     <= S_ONE;
                        out_valid <= 1'b1;
                        out_ctrl  <= in_ctrl;
                        out_rd    <= in_rd;
                        out_data  <= in_data;
                    end
                end
                S_ONE: begin
                    // in_ready is 1 here, so accept == in_valid and drain == out_ready.
                    case ({out_ready, in_valid})
                        2'b11: begin
                            out_ctrl <= in_ctrl;
                            out_rd   <= in_rd;
                            out_data <= in_data;
                        end
                        2'b10: begin
                            state     <= S_EMPTY;
                            out_valid <= 1'b0;
                            out_ctrl  <= CTRL_RST;
                            out_rd    <= '0;
                            out_data  <= '0;
                        end
                        2'b01: begin
                            state     <= S_TWO;
                            in_ready  <= 1'b0;
                            skid_ctrl <= in_ctrl;
                            skid_rd   <= in_rd;
                            skid_data <= in_data;
                        end
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (out_ready) begin
                        state     <= S_ONE;
                        in_ready  <= 1'b1;
                        out_ctrl  <= skid_ctrl;
                        out_rd    <= skid_rd;
                        out_data  <= skid_data;
                        skid_ctrl <= CTRL_RST;
                        skid_rd   <= '0;
                        skid_data <= '0;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_ctrl  <= CTRL_RST;
                    out_rd    <= '0;
                    out_data  <= '0;
                end
            endcase
        end
    end

    // Flush deliberately leaves the counter alone; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign fwd_valid = out_valid & out_ctrl[WE_BIT];
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
// Bench for pipe_stage_skid: directed vector table, stall/reset sequences, random scoreboard run.
// Two instances share stimulus: a full-width one (WE_BIT=2) and a 2-bit stall counter one (default WE_BIT=1).
// All expected values are constants or come from a queue model of the stage.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl = 8'h00;
    logic [3:0]  in_rd = 4'h0;
    logic [15:0] in_data = 16'h0;

    logic        in_ready, out_valid, fwd_valid;
    logic [7:0]  out_ctrl;
    logic [3:0]  out_rd, fwd_rd;
    logic [15:0] out_data, fwd_data, stall_cnt;

    logic        s_in_ready, s_out_valid, s_fwd_valid;
    logic [7:0]  s_out_ctrl;
    logic [3:0]  s_out_rd, s_fwd_rd;
    logic [15:0] s_out_data, s_fwd_data;
    logic [1:0]  s_stall_cnt;

    // WE_BIT=2 so the example control 8'h05 marks a register write on the tap.
    pipe_stage_skid #(.WE_BIT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_rd(s_out_rd), .out_data(s_out_data),
        .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  c;
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        logic iv, ordy, fl;
        ent_t in;
        logic e_irdy, e_ov;
        ent_t e_out;
        logic e_fv;
    } vec_t;

    localparam ent_t EA = '{c: 8'h05, r: 4'd3, d: 16'h1234};
    localparam ent_t EB = '{c: 8'h07, r: 4'd5, d: 16'hBEEF};
    localparam ent_t EC = '{c: 8'h09, r: 4'd6, d: 16'hC0DE};
    localparam ent_t ED = '{c: 8'h0F, r: 4'd9, d: 16'hDEAD};
    localparam ent_t EZ = '{c: 8'h01, r: 4'd0, d: 16'h0000};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic cyc(input logic iv, input logic ordy, input logic fl, input ent_t e);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = e.c;
        in_rd     = e.r;
        in_data   = e.d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input ent_t in,
                                input logic irdy, input logic ov, input ent_t eo, input logic fv);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.in = in;
        v.e_irdy = irdy; v.e_ov = ov; v.e_out = eo; v.e_fv = fv;
        return v;
    endfunction

    vec_t vt[22];
    ent_t q[$];
    ent_t e;
    ent_t exp_s;
    logic iv_r, or_r, acc;
    int   drains;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // T1: single entry passes through.
        vt[0]  = mk(1,1,0,EA, 1,1,EA,1);
        vt[1]  = mk(0,1,0,EZ, 1,0,EZ,0);
        // T2: stall, fill skid, third entry refused, then drain in order.
        vt[2]  = mk(1,0,0,EA, 1,1,EA,1);
        vt[3]  = mk(1,0,0,EB, 0,1,EA,1);
        vt[4]  = mk(1,0,0,EC, 0,1,EA,1);
        vt[5]  = mk(1,1,0,EC, 1,1,EB,1);
        vt[6]  = mk(1,1,0,EC, 1,1,EC,0);
        vt[7]  = mk(0,1,0,EZ, 1,0,EZ,0);
        // T3: flush while full with D offered.
        vt[8]  = mk(1,0,0,EA, 1,1,EA,1);
        vt[9]  = mk(1,0,0,EB, 0,1,EA,1);
        vt[10] = mk(1,0,1,ED, 1,0,EZ,0);
        vt[11] = mk(0,1,0,EZ, 1,0,EZ,0);
        // Flush with in_ready=1 still discards the offered entry.
        vt[12] = mk(1,0,0,EA, 1,1,EA,1);
        vt[13] = mk(1,1,1,ED, 1,0,EZ,0);
        vt[14] = mk(0,1,0,EZ, 1,0,EZ,0);
        // Streaming at one per cycle.
        vt[15] = mk(1,1,0,EA, 1,1,EA,1);
        vt[16] = mk(1,1,0,EB, 1,1,EB,1);
        vt[17] = mk(1,1,0,EC, 1,1,EC,0);
        vt[18] = mk(0,1,0,EZ, 1,0,EZ,0);
        // Hold in ONE with neither transfer.
        vt[19] = mk(1,0,0,ED, 1,1,ED,1);
        vt[20] = mk(0,0,0,EZ, 1,1,ED,1);
        vt[21] = mk(0,1,0,EZ, 1,0,EZ,0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out", {out_ctrl, out_rd, out_data}, EZ);
        chk("rst fwd_valid", fwd_valid, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            cyc(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].in);
            chk($sformatf("v%0d in_ready", i), in_ready, vt[i].e_irdy);
            chk($sformatf("v%0d out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("v%0d out", i), {out_ctrl, out_rd, out_data}, vt[i].e_out);
            chk($sformatf("v%0d fwd_valid", i), fwd_valid, vt[i].e_fv);
            chk($sformatf("v%0d fwd", i), {fwd_rd, fwd_data}, {vt[i].e_out.r, vt[i].e_out.d});
            exp_s = vt[i].e_out;
            chk($sformatf("v%0d s_in_ready", i), s_in_ready, vt[i].e_irdy);
            chk($sformatf("v%0d s_out_valid", i), s_out_valid, vt[i].e_ov);
            chk($sformatf("v%0d s_out", i), {s_out_ctrl, s_out_rd, s_out_data}, exp_s);
            chk($sformatf("v%0d s_fwd_valid", i), s_fwd_valid, vt[i].e_ov & exp_s.c[1]);
            chk($sformatf("v%0d s_fwd", i), {s_fwd_rd, s_fwd_data}, {exp_s.r, exp_s.d});
        end

        // T4: stall counter and saturation; asynchronous reset pulse first.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("T4 cnt after rst", stall_cnt, 0);
        cyc(1,0,0,EA);
        chk("T4 cnt first", stall_cnt, 0);
        repeat (5) cyc(0,0,0,EZ);
        chk("T4 cnt 5", stall_cnt, 5);
        chk("T4 s_cnt sat", s_stall_cnt, 3);
        chk("T4 stable data", {out_ctrl, out_rd, out_data}, EA);
        cyc(0,0,0,EZ);
        chk("T4 cnt 6", stall_cnt, 6);
        chk("T4 s_cnt 6", s_stall_cnt, 3);
        cyc(0,1,1,EZ);
        chk("T4 flush out_valid", out_valid, 0);
        chk("T4 flush keeps cnt", stall_cnt, 6);
        chk("T4 flush keeps s_cnt", s_stall_cnt, 3);

        // T5: asynchronous reset mid-cycle while holding one entry.
        cyc(1,0,0,EB);
        chk("T5 in ONE", out_valid, 1);
        cyc(0,0,0,EZ);
        chk("T5 cnt before rst", stall_cnt, 7);
        #3 rst = 1'b1;
        #1;
        chk("T5 async out_valid", out_valid, 0);
        chk("T5 async out", {out_ctrl, out_rd, out_data}, EZ);
        chk("T5 async in_ready", in_ready, 1);
        chk("T5 async cnt", stall_cnt, 0);
        chk("T5 async s_cnt", s_stall_cnt, 0);
        chk("T5 async fwd_valid", fwd_valid, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("T5 after release", out_valid, 0);

        // Throughput: 20 cycles with both sides always ready -> 19 drains.
        drains = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) drains++;
            e = ent_t'({8'(k), 4'(k), 16'(k * 3)});
            cyc(1,1,0,e);
        end
        chk("T6 throughput", drains, 19);
        cyc(0,1,0,EZ);
        chk("T6 idle after stream", out_valid, 0);

        // T6: random valid/ready against a FIFO scoreboard.
        q.delete();
        for (int n = 0; n < 10000; n++) begin
            iv_r = 1'($urandom_range(0, 1));
            or_r = ($urandom_range(0, 3) != 0);
            e = ent_t'({8'($urandom), 4'($urandom), 16'($urandom)});
            in_valid = iv_r; out_ready = or_r; flush = 1'b0;
            in_ctrl = e.c; in_rd = e.r; in_data = e.d;
            chk("T6 out_valid occ", out_valid, (q.size() > 0));
            chk("T6 in_ready occ", in_ready, (q.size() < 2));
            acc = iv_r && in_ready;
            if (or_r && out_valid) begin
                if (q.size() == 0) begin
                    chk("T6 underflow", 1, 0);
                end else begin
                    chk("T6 order", {out_ctrl, out_rd, out_data}, q[0]);
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (out_valid && q.size() > 0) begin
                chk("T6 tail order", {out_ctrl, out_rd, out_data}, q[0]);
                void'(q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        chk("T6 leftover", q.size(), 0);
        chk("T6 final out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
